// File: rtl/cpu_mem_ctrl.sv
// CPU program/data RAM shared with a host load/debug port; sequences CPU halt/release.
// Optional CPU write protection below PROT_LIMIT is enabled by defining CPU_MEM_WPROT_EN.
module cpu_mem_ctrl #(
    parameter int DEPTH        = 128,
    parameter bit BOOT_HALTED  = 1'b1,
    parameter int DRAIN_CYCLES = 2,
    parameter int PROT_LIMIT   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] cpu_address,
    input  logic [7:0] cpu_data_out,
    input  logic       cpu_write,
    output logic [7:0] cpu_data_in,
    output logic       cpu_reset,
    input  logic       host_halt,
    output logic       halted,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_gnt,
    output logic [7:0] host_rdata,
    output logic       prot_err
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] drain_cnt;
    logic [7:0]    mem [DEPTH];
    logic          cpu_active, host_acc, cpu_we;

    function automatic logic [IW-1:0] wrap(input logic [6:0] a);
        logic [7:0] m;
        m = {1'b0, a} % DEPTH8;
        return IW'(m);
    endfunction

    assign cpu_active  = (state == RUN) || (state == DRAIN);
    // No acceptance in the cycle a grant is shown, which spaces grants two cycles apart.
    assign host_acc    = reset && (state == HALTED) && host_req && !host_gnt;
    assign cpu_data_in = mem[wrap(cpu_address)];

`ifdef CPU_MEM_WPROT_EN
    logic cpu_prot, prot_hit, prot_q;
    assign cpu_prot = int'(cpu_address) < PROT_LIMIT;
    assign cpu_we   = cpu_write && cpu_active && !cpu_prot;
    assign prot_hit = cpu_write && cpu_active && cpu_prot;
    assign prot_err = prot_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  prot_q <= 1'b0;
        else if (prot_hit)           prot_q <= 1'b1;
        else if (host_acc && host_we) prot_q <= 1'b0;
    end
`else
    assign cpu_we   = cpu_write && cpu_active;
    assign prot_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (host_halt) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == CW'(DRAIN_CYCLES - 1)) state_nxt = HALTED;
            HALTED:  if (!host_halt && !host_req && !host_gnt) state_nxt = RELEASE;
            RELEASE: state_nxt = RUN;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT_HALTED ? HALTED : RELEASE;
            drain_cnt  <= '0;
            cpu_reset  <= 1'b1;
            halted     <= 1'b0;
            host_gnt   <= 1'b0;
            host_rdata <= 8'h00;
        end else begin
            state      <= state_nxt;
            drain_cnt  <= (state == DRAIN) ? drain_cnt + CW'(1) : '0;
            // Registered from next state so the CPU is held from the very edge halt is seen.
            cpu_reset  <= (state_nxt != RUN);
            halted     <= (state_nxt == HALTED);
            host_gnt   <= host_acc;
            if (host_acc && !host_we) host_rdata <= mem[wrap(host_addr)];
        end
    end

    // Host and CPU writers are exclusive by state, so one port suffices.
    always_ff @(posedge clk) begin
        if (host_acc && host_we) mem[wrap(host_addr)] <= host_wdata;
        else if (cpu_we)         mem[wrap(cpu_address)] <= cpu_data_out;
    end
endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Scoreboard bench for cpu_mem_ctrl: host reads are queued at request time and checked on grant.
module tb_cpu_mem_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] cpu_address;
    logic [7:0] cpu_data_out;
    logic       cpu_write;
    logic [7:0] cpu_data_in;
    logic       cpu_reset;
    logic       host_halt;
    logic       halted;
    logic       host_req;
    logic       host_we;
    logic [6:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       prot_err;

    typedef struct {
        bit         is_read;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] model [128];
    logic       prev_gnt = 1'b0;
    int         vec  = 0;
    int         miss = 0;

    cpu_mem_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_data_out(cpu_data_out), .cpu_write(cpu_write),
        .cpu_data_in(cpu_data_in), .cpu_reset(cpu_reset),
        .host_halt(host_halt), .halted(halted),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .prot_err(prot_err)
    );

    always #5 clk = ~clk;

    // Grant monitor: pops one scoreboard entry per grant, checks read data and grant spacing.
    always @(negedge clk) begin
        if (host_gnt === 1'b1) begin
            vec++;
            if (prev_gnt === 1'b1) begin
                miss++;
                $display("FAIL gnt_spacing: grant seen in two consecutive cycles");
            end
            if (sb.size() == 0) begin
                vec++; miss++;
                $display("FAIL gnt_unexpected: grant with no outstanding request");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_read) begin
                    vec++;
                    if (host_rdata !== mon_e.data) begin
                        miss++;
                        $display("FAIL host_rdata: got %02h expected %02h", host_rdata, mon_e.data);
                    end
                end
            end
        end
        prev_gnt = host_gnt;
    end

    task automatic push_exp(input bit we, input logic [6:0] a);
        exp_t e;
        e.is_read = !we;
        e.data    = model[a];
        sb.push_back(e);
    endtask

    task automatic host_access(input bit we, input logic [6:0] a, input logic [7:0] d);
        int n;
        n = 0;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        push_exp(we, a);
        if (we) model[a] = d;
        do begin
            @(negedge clk);
            n++;
        end while (host_gnt !== 1'b1 && n < 20);
        vec++;
        if (host_gnt !== 1'b1) begin
            miss++;
            $display("FAIL host_timeout: gnt=%b expected 1 within 20 cycles", host_gnt);
            sb.delete();
        end
        host_req = 1'b0;
    endtask

    task automatic cpu_store(input logic [6:0] a, input logic [7:0] d, input bit commits);
        cpu_address = a; cpu_data_out = d; cpu_write = 1'b1;
        @(negedge clk);
        cpu_write = 1'b0;
        if (commits) model[a] = d;
    endtask

    task automatic cpu_check(input logic [6:0] a, input string nm);
        cpu_address = a;
        #1;
        vec++;
        if (cpu_data_in !== model[a]) begin
            miss++;
            $display("FAIL %s: cpu_data_in[%0d] got %02h expected %02h", nm, a, cpu_data_in, model[a]);
        end
    endtask

    task automatic go_run();
        int n;
        n = 0;
        @(negedge clk);
        host_halt = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_reset !== 1'b0 && n < 10);
        vec++;
        if (cpu_reset !== 1'b0) begin
            miss++;
            $display("FAIL run_timeout: cpu_reset=%b expected 0", cpu_reset);
        end
    endtask

    task automatic go_halt();
        int n;
        n = 0;
        host_halt = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (halted !== 1'b1 && n < 10);
        vec++;
        if (halted !== 1'b1) begin
            miss++;
            $display("FAIL halt_timeout: halted=%b expected 1", halted);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        vec += 5;
        if (cpu_reset !== 1'b1)    begin miss++; $display("FAIL rst_cpu_reset: got %b expected 1", cpu_reset); end
        if (halted !== 1'b0)       begin miss++; $display("FAIL rst_halted: got %b expected 0", halted); end
        if (host_gnt !== 1'b0)     begin miss++; $display("FAIL rst_gnt: got %b expected 0", host_gnt); end
        if (host_rdata !== 8'h00)  begin miss++; $display("FAIL rst_rdata: got %02h expected 00", host_rdata); end
        if (prot_err !== 1'b0)     begin miss++; $display("FAIL rst_prot: got %b expected 0", prot_err); end
        reset = 1'b1;
        @(negedge clk);
        vec += 2;
        if (halted !== 1'b1)    begin miss++; $display("FAIL boot_halted: got %b expected 1", halted); end
        if (cpu_reset !== 1'b1) begin miss++; $display("FAIL boot_cpu_reset: got %b expected 1", cpu_reset); end
    endtask

    task automatic test_boot_load();
        for (int i = 0; i < 16; i++) host_access(1'b1, 7'(i), 8'hC0 | 8'(i));
        host_access(1'b0, 7'd0, 8'h00);
        host_access(1'b0, 7'd7, 8'h00);
        host_access(1'b0, 7'd15, 8'h00);
        @(negedge clk);
        host_halt = 1'b0;
        @(negedge clk);
        vec += 2;
        if (cpu_reset !== 1'b1) begin miss++; $display("FAIL release_cpu_reset: got %b expected 1", cpu_reset); end
        if (halted !== 1'b0)    begin miss++; $display("FAIL release_halted: got %b expected 0", halted); end
        @(negedge clk);
        vec++;
        if (cpu_reset !== 1'b0) begin miss++; $display("FAIL run_cpu_reset: got %b expected 0", cpu_reset); end
        cpu_check(7'd0, "boot_fetch");
    endtask

    task automatic test_cpu_rw();
        cpu_store(7'd20, 8'h21, 1'b1);
        cpu_store(7'd40, 8'h42, 1'b1);
        cpu_store(7'd127, 8'h7F, 1'b1);
        cpu_check(7'd20, "cpu_rw20");
        cpu_check(7'd40, "cpu_rw40");
        cpu_check(7'd127, "cpu_rw127");
        cpu_check(7'd9, "cpu_rw9");
    endtask

    task automatic test_halt_drain();
        @(negedge clk);
        cpu_address = 7'd3; cpu_data_out = 8'h5A; cpu_write = 1'b1; host_halt = 1'b1;
        @(negedge clk);
        model[3] = 8'h5A;
        cpu_address = 7'd50; cpu_data_out = 8'h3C;
        vec += 2;
        if (cpu_reset !== 1'b1) begin miss++; $display("FAIL drain_cpu_reset: got %b expected 1", cpu_reset); end
        if (halted !== 1'b0)    begin miss++; $display("FAIL drain1_halted: got %b expected 0", halted); end
        @(negedge clk);
        cpu_write = 1'b0;
        model[50] = 8'h3C;
        vec++;
        if (halted !== 1'b0) begin miss++; $display("FAIL drain2_halted: got %b expected 0", halted); end
        @(negedge clk);
        vec++;
        if (halted !== 1'b1) begin miss++; $display("FAIL drain_done_halted: got %b expected 1", halted); end
        cpu_store(7'd40, 8'hFF, 1'b0);
        cpu_check(7'd3, "halt_store3");
        cpu_check(7'd50, "drain_store50");
        cpu_check(7'd40, "halted_store_dropped");
    endtask

    task automatic test_host_read();
        host_access(1'b0, 7'd3, 8'h00);
        host_access(1'b0, 7'd50, 8'h00);
        host_access(1'b0, 7'd40, 8'h00);
        host_access(1'b1, 7'd100, 8'hA5);
        host_access(1'b0, 7'd100, 8'h00);
        cpu_check(7'd100, "host_write_cpu_view");
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 7'd3;
        push_exp(1'b0, 7'd3);
        do begin
            @(negedge clk);
            n++;
        end while (host_gnt !== 1'b1 && n < 20);
        push_exp(1'b0, 7'd50);
        host_addr = 7'd50;
        @(negedge clk);
        vec++;
        if (host_gnt !== 1'b0) begin miss++; $display("FAIL b2b_gap: gnt got %b expected 0", host_gnt); end
        @(negedge clk);
        vec++;
        if (host_gnt !== 1'b1) begin miss++; $display("FAIL b2b_second: gnt got %b expected 1", host_gnt); end
        host_req = 1'b0;
        if (host_gnt !== 1'b1) sb.delete();
    endtask

    task automatic test_blocked_host();
        int n;
        n = 0;
        @(negedge clk);
        go_run();
        host_req = 1'b1; host_we = 1'b0; host_addr = 7'd20;
        push_exp(1'b0, 7'd20);
        repeat (3) begin
            @(negedge clk);
            vec++;
            if (host_gnt !== 1'b0) begin miss++; $display("FAIL blocked_run_gnt: got %b expected 0", host_gnt); end
        end
        host_halt = 1'b1;
        do begin
            @(negedge clk);
            n++;
            vec++;
            if (host_gnt !== 1'b0) begin miss++; $display("FAIL blocked_drain_gnt: got %b expected 0", host_gnt); end
        end while (halted !== 1'b1 && n < 10);
        @(negedge clk);
        vec++;
        if (host_gnt !== 1'b1) begin
            miss++;
            $display("FAIL blocked_first_gnt: got %b expected 1", host_gnt);
            sb.delete();
        end
        host_req = 1'b0;
    endtask

    task automatic test_wprot();
        @(negedge clk);
        go_run();
`ifdef CPU_MEM_WPROT_EN
        cpu_store(7'd2, 8'hEE, 1'b0);
        vec++;
        if (prot_err !== 1'b1) begin miss++; $display("FAIL prot_set: got %b expected 1", prot_err); end
        cpu_store(7'd20, 8'h99, 1'b1);
        vec++;
        if (prot_err !== 1'b1) begin miss++; $display("FAIL prot_sticky: got %b expected 1", prot_err); end
`else
        cpu_store(7'd2, 8'hEE, 1'b1);
        vec++;
        if (prot_err !== 1'b0) begin miss++; $display("FAIL prot_tied: got %b expected 0", prot_err); end
        cpu_store(7'd20, 8'h99, 1'b1);
`endif
        cpu_check(7'd2, "prot_addr2");
        cpu_check(7'd20, "prot_addr20");
        go_halt();
        host_access(1'b1, 7'd101, 8'h11);
        vec++;
        if (prot_err !== 1'b0) begin miss++; $display("FAIL prot_clear: got %b expected 0", prot_err); end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 7'd3;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        vec += 3;
        if (host_gnt !== 1'b0)  begin miss++; $display("FAIL midrst_gnt: got %b expected 0", host_gnt); end
        if (cpu_reset !== 1'b1) begin miss++; $display("FAIL midrst_cpu_reset: got %b expected 1", cpu_reset); end
        if (halted !== 1'b0)    begin miss++; $display("FAIL midrst_halted: got %b expected 0", halted); end
        host_req = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vec++;
        if (halted !== 1'b1) begin miss++; $display("FAIL midrst_rehalt: got %b expected 1", halted); end
        host_access(1'b0, 7'd3, 8'h00);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cpu_address = '0; cpu_data_out = '0; cpu_write = 1'b0;
        host_halt = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        test_reset();
        test_boot_load();
        test_cpu_rw();
        test_halt_drain();
        test_host_read();
        test_back_to_back();
        test_blocked_host();
        test_wprot();
        test_reset_mid_access();
        vec++;
        if (sb.size() != 0) begin
            miss++;
            $display("FAIL sb_drain: %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
